// File: rtl/seq_divider_16_if.sv
// Start/done handshake and result bundle for the sequential signed divider.
// The master issues operands and start; the slave is the divider.
interface seq_divider_16_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_16.sv
// Signed multi-cycle restoring divider: one quotient bit per clock, with
// saturating results for divide-by-zero and the NEG_SAT / -1 overflow case.
module seq_divider_16 #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POS_SAT = 16'h7FFF,
  parameter logic [WIDTH-1:0] NEG_SAT = 16'h8000
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_16_if.slave    bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // stored partial remainder is always < divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    // One restoring step on a WIDTH+1 bit partial remainder.
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dsr_q};
    qbit      = ~diff[WIDTH];
    q_mag     = {dvd_q[WIDTH-2:0], qbit};
    r_mag     = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];

    dvd_mag   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dsr_mag   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          quo_d = '0;
          rmd_d = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (bus.divisor == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b1;
            rmd_d   = bus.dividend;
            quo_d   = bus.dividend[WIDTH-1] ? NEG_SAT : POS_SAT;
            state_d = DONE;
          end else if (bus.dividend == NEG_SAT && bus.divisor == '1) begin
            quo_d   = POS_SAT;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d     = dvd_mag;
            dsr_d     = dsr_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_d = bus.dividend[WIDTH-1];
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = r_mag;
        dvd_d = q_mag;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = neg_quo_q ? -q_mag : q_mag;
          rmd_d   = neg_rem_q ? -r_mag : r_mag;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above; datapath flops are reset too so a reset
  // mid-operation leaves the outputs at zero as well as the FSM idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider_16.sv
// Directed and random bench for seq_divider_16: expected results are queued
// at launch from an arithmetic reference model and compared on done.
module tb_seq_divider_16;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider_16_if #(.WIDTH(W)) bus ();

  seq_divider_16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sb_i;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 16'h0000) begin
      e.q   = a[W-1] ? 16'h8000 : 16'h7FFF;
      e.r   = a;
      e.dbz = 1'b1;
      e.ovf = 1'b1;
      e.lat = 1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      e.q   = 16'h7FFF;
      e.r   = 16'h0000;
      e.ovf = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = 16'(sa / sb_i);
      e.r   = 16'(sa % sb_i);
      e.lat = W + 1;
    end
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
  endtask

  // Waits for done (bounded), then pops and compares the oldest expectation.
  task automatic wait_done(input string tag, input bit hold);
    int   lat    = 0;
    int   busy_n = 0;
    bit   seen   = 1'b0;
    exp_t e;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    last = e;
    if (seen) begin
      check({tag, " quotient"},    32'(bus.quotient),    32'(e.q));
      check({tag, " remainder"},   32'(bus.remainder),   32'(e.r));
      check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
      check({tag, " overflow"},    32'(bus.overflow),    32'(e.ovf));
      check({tag, " latency"},     32'(lat),             32'(e.lat));
      check({tag, " busy_cycles"}, 32'(busy_n),          32'(e.lat));
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           done_n;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset busy",      32'(bus.busy),        32'd0);
    check("reset done",      32'(bus.done),        32'd0);
    check("reset quotient",  32'(bus.quotient),    32'd0);
    check("reset remainder", 32'(bus.remainder),   32'd0);
    check("reset dbz",       32'(bus.div_by_zero), 32'd0);
    check("reset ovf",       32'(bus.overflow),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7, then confirm one-cycle done and held results
    launch(16'h0064, 16'h0007);
    wait_done("100/7", 1'b0);
    check("100/7 q const", 32'(bus.quotient),  32'h000E);
    check("100/7 r const", 32'(bus.remainder), 32'h0002);
    @(negedge clk);
    check("100/7 done drop", 32'(bus.done),     32'd0);
    check("100/7 idle",      32'(bus.busy),     32'd0);
    check("100/7 q hold",    32'(bus.quotient), 32'h000E);

    launch(16'hFF9C, 16'h0007);
    wait_done("-100/7", 1'b0);
    check("-100/7 q const", 32'(bus.quotient),  32'hFFF2);
    check("-100/7 r const", 32'(bus.remainder), 32'hFFFE);
    launch(16'h0064, 16'hFFF9);
    wait_done("100/-7", 1'b0);
    check("100/-7 q const", 32'(bus.quotient),  32'hFFF2);
    check("100/-7 r const", 32'(bus.remainder), 32'h0002);
    launch(16'hFF9C, 16'hFFF9);
    wait_done("-100/-7", 1'b0);
    check("-100/-7 q const", 32'(bus.quotient),  32'h000E);
    check("-100/-7 r const", 32'(bus.remainder), 32'hFFFE);

    launch(16'h0005, 16'h0000);
    wait_done("5/0", 1'b0);
    check("5/0 q const", 32'(bus.quotient), 32'h7FFF);
    launch(16'hFFFB, 16'h0000);
    wait_done("-5/0", 1'b0);
    check("-5/0 q const", 32'(bus.quotient), 32'h8000);

    launch(16'h8000, 16'hFFFF);
    wait_done("min/-1", 1'b0);
    check("min/-1 q const", 32'(bus.quotient), 32'h7FFF);
    launch(16'h8000, 16'h0001);
    wait_done("min/1", 1'b0);
    check("min/1 q const", 32'(bus.quotient), 32'h8000);
    launch(16'h0000, 16'h0005);
    wait_done("0/5", 1'b0);

    // start held through CALC with new operands, then back-to-back start
    launch(16'h0064, 16'h0007);
    #1;
    bus.dividend = 16'h04D2;
    bus.divisor  = 16'h0005;
    wait_done("held start", 1'b1);
    check("held start q const", 32'(bus.quotient), 32'h000E);
    launch(16'hFF9C, 16'h0007);
    wait_done("back2back", 1'b0);

    // reset in the middle of a divide
    launch(16'h0064, 16'h0007);
    repeat (8) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    check("midrst busy",      32'(bus.busy),        32'd0);
    check("midrst done",      32'(bus.done),        32'd0);
    check("midrst quotient",  32'(bus.quotient),    32'd0);
    check("midrst remainder", 32'(bus.remainder),   32'd0);
    check("midrst flags",     32'({bus.div_by_zero, bus.overflow}), 32'd0);
    done_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_n++;
    end
    check("midrst no done", 32'(done_n), 32'd0);
    launch(16'h7FFF, 16'h0003);
    wait_done("after rst", 1'b0);

    // random sweep, back-to-back
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      else                           b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (b == 16'h0000) b = 16'h0001;
      if (a == 16'h8000 && b == 16'hFFFF) b = 16'h0001;
      launch(a, b);
      wait_done("random", 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
